// File: rtl/shift_counter_pkg.sv
// ============================================================================
// Module      : shift_counter_pkg
// Description : Shared types and seed helper for the ring/Johnson shift counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_counter_pkg;

  typedef enum logic {
    MODE_RING    = 1'b0,
    MODE_JOHNSON = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam int c_max_width = 64;

  // Start-of-sequence value; callers truncate to their own width.
  function automatic logic [c_max_width-1:0] seed(input mode_e m, input int width);
    logic [c_max_width-1:0] s;
    s = '0;
    if (m == MODE_RING && width > 0) s[0] = 1'b1;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_counter_legal.sv
// ============================================================================
// Module      : shift_counter_legal
// Description : Combinational check that a value is a reachable state for the mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_counter_legal
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] val,
  input  logic             mode,
  output logic             legal
);

  logic [WIDTH-2:0] w_trans;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_trans
      assign w_trans[gi] = val[gi] ^ val[gi+1];
    end
  endgenerate

  // Johnson states have at most one edge between adjacent bits (non-cyclic).
  assign legal = (mode == MODE_JOHNSON) ? ($countones(w_trans) <= 1)
                                        : ($countones(val) == 1);

endmodule

`default_nettype wire

// File: rtl/shift_counter.sv
// ============================================================================
// Module      : shift_counter
// Description : WIDTH-bit ring / Johnson shift counter with load, reseed and self-correction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_counter
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             err
);

  logic [WIDTH-1:0] r_q;
  logic             r_mode_q;
  logic             r_wrap;
  logic             r_err;

  mode_e            w_mode;
  logic [WIDTH-1:0] w_seed;
  logic             w_flip;
  logic [WIDTH-1:0] w_step;
  logic             w_q_legal;
  logic             w_load_legal;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_wrap_nxt;
  logic             w_err_nxt;

  assign w_mode = mode_e'(mode);
  assign w_seed = WIDTH'(seed(w_mode, WIDTH));
  assign w_flip = (w_mode == MODE_JOHNSON);

  // Johnson differs from ring only by inverting the bit that wraps around.
  assign w_step = (dir == DIR_RIGHT) ? {r_q[0] ^ w_flip, r_q[WIDTH-1:1]}
                                     : {r_q[WIDTH-2:0], r_q[WIDTH-1] ^ w_flip};

  shift_counter_legal #(.WIDTH(WIDTH)) u_legal_q (
    .val   (r_q),
    .mode  (mode),
    .legal (w_q_legal)
  );

  shift_counter_legal #(.WIDTH(WIDTH)) u_legal_load (
    .val   (load_val),
    .mode  (mode),
    .legal (w_load_legal)
  );

  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    w_err_nxt  = 1'b0;
    if (load) begin
      if (w_load_legal) begin
        w_q_nxt = load_val;
      end else begin
        w_q_nxt   = w_seed;
        w_err_nxt = 1'b1;
      end
    end else if (mode != r_mode_q) begin
      w_q_nxt = w_seed;
    end else if (!w_q_legal) begin
      w_q_nxt   = w_seed;
      w_err_nxt = 1'b1;
    end else if (en) begin
      w_q_nxt    = w_step;
      w_wrap_nxt = (w_step == w_seed);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q      <= w_seed;
      r_mode_q <= mode;
      r_wrap   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_q      <= w_q_nxt;
      r_mode_q <= mode;
      r_wrap   <= w_wrap_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;
  assign err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_shift_counter.sv
// ============================================================================
// Module      : tb_shift_counter
// Description : Self-checking bench for shift_counter against a sequence-index model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_counter;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         en;
  logic         mode;
  logic         dir;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         wrap;
  logic         err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] mq;
  logic         mmq;

  shift_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .wrap     (wrap),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int period(input logic m);
    return m ? 2 * W : W;
  endfunction

  // k-th state of the sequence starting from seed and stepping left.
  function automatic logic [W-1:0] tval(input logic m, input int k);
    int v;
    if (!m)        v = 1 << k;
    else if (k <= W) v = (1 << k) - 1;
    else           v = ((1 << W) - 1) & ~((1 << (k - W)) - 1);
    return v[W-1:0];
  endfunction

  function automatic int idx_of(input logic [W-1:0] v, input logic m);
    for (int k = 0; k < period(m); k++)
      if (tval(m, k) == v) return k;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic ld,
                      input logic [W-1:0] lv, input logic e, input logic m,
                      input logic d);
    logic [W-1:0] eq;
    logic         ew;
    logic         ee;
    int           k;
    @(negedge clk);
    reset = r; load = ld; load_val = lv; en = e; mode = m; dir = d;
    eq = mq; ew = 1'b0; ee = 1'b0;
    if (r) begin
      eq = tval(m, 0);
    end else if (ld) begin
      if (idx_of(lv, m) >= 0) eq = lv;
      else begin eq = tval(m, 0); ee = 1'b1; end
    end else if (m != mmq) begin
      eq = tval(m, 0);
    end else if (idx_of(mq, m) < 0) begin
      eq = tval(m, 0); ee = 1'b1;
    end else if (e) begin
      k  = idx_of(mq, m);
      k  = d ? (k + period(m) - 1) % period(m) : (k + 1) % period(m);
      eq = tval(m, k);
      ew = (k == 0);
    end
    mq  = eq;
    mmq = m;
    @(posedge clk);
    #1;
    check({tag, ".q"},    32'(q),    32'(eq));
    check({tag, ".wrap"}, 32'(wrap), 32'(ew));
    check({tag, ".err"},  32'(err),  32'(ee));
  endtask

  initial begin
    logic         rm;
    logic         rr;
    logic         rl;
    logic [W-1:0] rv;
    reset = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
    mq = '0; mmq = 1'b0;

    // Ring left through one full period
    step("rst_ring", 1, 0, 0, 0, 0, 0);
    check("rst_ring.lit", 32'(q), 32'(4'b0001));
    for (int i = 0; i < 4; i++) step("ring_left", 0, 0, 0, 1, 0, 0);
    check("ring_left.lit", 32'(q), 32'(4'b0001));

    // Johnson left through one full period
    step("rst_john", 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step("john_left", 0, 0, 0, 1, 1, 0);
    check("john_left.lit", 32'(q), 32'(4'b0000));
    for (int i = 0; i < 5; i++) step("john_right", 0, 0, 0, 1, 1, 1);

    // Ring right with a direction flip
    step("rst_ring2", 1, 0, 0, 0, 0, 0);
    step("ring_right", 0, 0, 0, 1, 0, 1);
    step("ring_right", 0, 0, 0, 1, 0, 1);
    step("dir_flip", 0, 0, 0, 1, 0, 0);
    check("dir_flip.lit", 32'(q), 32'(4'b1000));
    for (int i = 0; i < 4; i++) step("ring_right", 0, 0, 0, 1, 0, 1);

    // Loads, legal and illegal, in both modes
    step("load_ok", 0, 1, 4'b0100, 0, 0, 0);
    step("load_bad", 0, 1, 4'b0110, 0, 0, 0);
    check("load_bad.lit", 32'({q, err}), 32'({4'b0001, 1'b1}));
    step("to_john", 0, 0, 0, 0, 1, 0);
    step("load_bad_j", 0, 1, 4'b0101, 0, 1, 0);
    step("load_ok_j", 0, 1, 4'b1100, 0, 1, 0);
    step("load_en", 0, 1, 4'b1110, 1, 1, 0);

    // Mode toggle with en reseeds instead of stepping
    step("to_ring", 0, 0, 0, 0, 0, 0);
    step("load_0100", 0, 1, 4'b0100, 0, 0, 0);
    step("mode_tog", 0, 0, 0, 1, 1, 0);
    check("mode_tog.lit", 32'(q), 32'(4'b0000));

    // Illegal state injected directly into the register
    step("rst_ring3", 1, 0, 0, 0, 0, 0);
    #1 force dut.r_q = 4'b1010;
    #1 release dut.r_q;
    mq = 4'b1010;
    step("correct", 0, 0, 0, 0, 0, 0);
    check("correct.lit", 32'({q, err}), 32'({4'b0001, 1'b1}));

    // Reset beats load and en
    step("load_0100b", 0, 1, 4'b0100, 0, 0, 0);
    step("rst_prio", 1, 1, 4'b1000, 1, 0, 0);

    // Randomised traffic
    rm = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) rm = ~rm;
      rr = ($urandom_range(0, 49) == 0);
      rl = ($urandom_range(0, 6) == 0);
      rv = $urandom_range(0, 1) ? tval(rm, $urandom_range(0, period(rm) - 1))
                                : W'($urandom);
      step("rand", rr, rl, rv, ($urandom_range(0, 9) < 7), rm, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
